// File: rtl/data_bus_interconnect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_bus_interconnect: round-robin N-master to M-slave request router with  |
// | mask/base address decode, one outstanding transfer and response timeout.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module data_bus_interconnect #(
  parameter int                          NUM_MASTERS = 2,
  parameter int                          NUM_SLAVES  = 8,
  parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE  = '0,
  parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK  = '0,
  parameter int                          TIMEOUT     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_MASTERS-1:0]             m_req,
  input  logic [NUM_MASTERS-1:0][31:0]       m_addr,
  output logic [NUM_MASTERS-1:0]             m_gnt,
  output logic [NUM_MASTERS-1:0]             m_rvalid,
  output logic [NUM_MASTERS-1:0]             m_err,
  output logic [NUM_SLAVES-1:0]              s_req,
  input  logic [NUM_SLAVES-1:0]              s_rvalid,
  output logic [$clog2(NUM_SLAVES+1)-1:0]    resp_slave,
  output logic                               busy
);

  localparam int              c_MW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int              c_SW      = $clog2(NUM_SLAVES + 1);
  localparam logic [7:0]      c_TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [c_SW-1:0] c_NONE    = c_SW'(NUM_SLAVES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_ERR_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_MW-1:0] r_ptr;
  logic [c_MW-1:0] r_master;
  logic [7:0]      r_cnt;
  logic [c_SW-1:0] r_resp_slave;

  logic            w_gnt_found;
  logic [c_MW-1:0] w_gnt_idx;
  logic [31:0]     w_addr;
  logic            w_mapped;
  logic [c_SW-1:0] w_sel;
  logic            w_resp_hit;
  logic            w_timeout;
  logic            w_grant;

  // Descending search so the first requester at or after r_ptr wins.
  always_comb begin : p_arb
    int idx;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    idx         = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (m == idx && m_req[m]) begin
          w_gnt_found = 1'b1;
          w_gnt_idx   = c_MW'(m);
        end
      end
    end
  end

  always_comb begin : p_decode
    w_addr = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (w_gnt_idx == c_MW'(m)) w_addr = m_addr[m];
    end
    w_mapped = 1'b0;
    w_sel    = c_NONE;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((w_addr & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i])) begin
        w_mapped = 1'b1;
        w_sel    = c_SW'(i);
      end
    end
  end

  always_comb begin : p_resp
    w_resp_hit = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_resp_slave == c_SW'(i)) w_resp_hit = s_rvalid[i];
    end
    w_resp_hit = w_resp_hit && (r_state == S_WAIT);
    w_timeout  = (r_state == S_WAIT) && !w_resp_hit && (r_cnt == c_TO_LAST);
    w_grant    = !rst && w_gnt_found && ((r_state == S_IDLE) || w_resp_hit);
  end

  always_comb begin : p_out
    m_gnt    = '0;
    m_rvalid = '0;
    m_err    = '0;
    s_req    = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      m_gnt[m]    = w_grant && (w_gnt_idx == c_MW'(m));
      m_rvalid[m] = !rst && (r_master == c_MW'(m)) &&
                    (w_resp_hit || w_timeout || (r_state == S_ERR_RESP));
      m_err[m]    = !rst && (r_master == c_MW'(m)) &&
                    (w_timeout || (r_state == S_ERR_RESP));
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_req[i] = w_grant && w_mapped && (w_sel == c_SW'(i));
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign resp_slave = r_resp_slave;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_master     <= '0;
      r_cnt        <= '0;
      r_resp_slave <= c_NONE;
    end else if (w_grant) begin
      r_master <= w_gnt_idx;
      r_ptr    <= (w_gnt_idx == c_MW'(NUM_MASTERS - 1)) ? '0 : w_gnt_idx + 1'b1;
      r_cnt    <= '0;
      if (w_mapped) begin
        r_resp_slave <= w_sel;
        r_state      <= S_WAIT;
      end else begin
        r_resp_slave <= c_NONE;
        r_state      <= S_ERR_RESP;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_resp_hit || w_timeout) r_state <= S_IDLE;
          else                         r_cnt   <= r_cnt + 8'd1;
        end
        S_ERR_RESP: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/data_bus_interconnect.md
DATA_BUS_INTERCONNECT -- requirements
Module: data_bus_interconnect

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of requesting masters, range 1..8.
REQ-002 SHALL have parameter NUM_SLAVES, default 8: number of decoded slaves, range 1..16.
REQ-003 SHALL have parameter SLAVE_BASE, default all-zero packed array [NUM_SLAVES][32]: slave base addresses.
REQ-004 SHALL have parameter SLAVE_MASK, default all-zero packed array [NUM_SLAVES][32]: address compare masks; a 1 bit is compared.
REQ-005 SHALL have parameter TIMEOUT, default 16: maximum response wait in cycles, range 2..255.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port m_req, input, NUM_MASTERS: per-master request.
REQ-009 SHALL have port m_addr, input, NUM_MASTERS x 32: per-master address.
REQ-010 SHALL have port m_gnt, output, NUM_MASTERS: one-hot grant, combinational.
REQ-011 SHALL have port m_rvalid, output, NUM_MASTERS: one-hot response valid to the owning master.
REQ-012 SHALL have port m_err, output, NUM_MASTERS: error flag, qualified by m_rvalid.
REQ-013 SHALL have port s_req, output, NUM_SLAVES: one-hot slave select, asserted with the grant.
REQ-014 SHALL have port s_rvalid, input, NUM_SLAVES: per-slave response valid.
REQ-015 SHALL have port resp_slave, output, $clog2(NUM_SLAVES+1): slave index owning the current response; NUM_SLAVES means none/error.
REQ-016 SHALL have port busy, output, 1: a transaction is outstanding.

Function
REQ-017 SHALL decode an address to slave i when (addr & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i]); on multiple matches, the lowest i SHALL win.
REQ-018 SHALL implement states IDLE, WAIT and ERR_RESP, with one outstanding transaction at most.
REQ-019 SHALL grant in IDLE, or in WAIT during the cycle the awaited s_rvalid arrives, so back-to-back transfers lose no cycle.
REQ-020 SHALL arbitrate round-robin: search starts at the master after the last granted one (wrap NUM_MASTERS-1 -> 0); the pointer SHALL update only on a grant.
REQ-021 SHALL, on a grant to a mapped address, assert s_req[i] for that same cycle, latch the master index, set resp_slave=i, load the timeout counter to 0, and go to WAIT.
REQ-022 SHALL, on a grant to an unmapped address, assert no s_req, set resp_slave=NUM_SLAVES, and go to ERR_RESP.
REQ-023 SHALL, in ERR_RESP, assert m_rvalid and m_err to the latched master for exactly one cycle, then go to IDLE; no grant is issued in that cycle.
REQ-024 SHALL, in WAIT, route s_rvalid[resp_slave] to m_rvalid of the latched master with m_err=0; s_rvalid of any other slave SHALL be ignored.
REQ-025 SHALL, in WAIT, increment the counter each cycle without a response; at counter == TIMEOUT-1 with no response, it SHALL assert m_rvalid and m_err for one cycle and go to IDLE.
REQ-026 SHALL, when a response and the timeout coincide, treat the transfer as a normal response with m_err=0.
REQ-027 SHALL keep busy=1 in WAIT and ERR_RESP and busy=0 in IDLE.
REQ-028 SHALL ensure m_gnt, s_req and m_rvalid are each at most one-hot in every cycle.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, round-robin pointer 0 (master 0 has priority first), counter 0, resp_slave=NUM_SLAVES, and m_gnt, m_rvalid, m_err, s_req and busy all 0.
REQ-030 SHALL, on reset asserted mid-transaction, drop it with no m_rvalid; a slave response arriving after reset SHALL be ignored.

Verification
REQ-031 SHALL pass this scenario: NUM_MASTERS=2, slave 2 base 0x0002_0000, mask 0xFFFF_0000; m0 requests 0x0002_0010 -> same cycle m_gnt=01 and s_req[2]=1; s_rvalid[2] 3 cycles later -> m_rvalid=01, m_err=0, busy falls next cycle.
REQ-032 SHALL pass this scenario: both masters hold m_req continuously, each slave responding in 1 cycle -> grants alternate 01,10,01,10 with no idle cycle between transfers.
REQ-033 SHALL pass this scenario: m1 requests unmapped 0xDEAD_0000 -> m_gnt=10, s_req=0, next cycle m_rvalid=10 and m_err=10, resp_slave=NUM_SLAVES.
REQ-034 SHALL pass this scenario: TIMEOUT=4, slave never responds -> exactly 4 cycles after the grant cycle, m_rvalid with m_err=1 for one cycle, then IDLE.
REQ-035 SHALL pass this scenario: rst pulsed in WAIT, then the slave responds -> no m_rvalid, busy=0, and the next grant goes to m0.
REQ-036 SHALL pass this scenario: overlapping masks for slaves 1 and 3, address matching both -> s_req[1] only.
